fir_filter: RTL and testbench
=============================

Name: fir_filter

Overview:
- Fixed-coefficient, 8-tap, direct-form low-pass FIR filter for a signed 24-bit sample stream.
- Accepts one sample on every clock; there is no valid/ready handshake.
- Sits in the audio/DSP datapath between the sample source and downstream consumers.
- Produces one filtered signed 24-bit sample per clock.

Parameters:
- WD_IN, 24, input sample width (signed two's complement).
- WD_OUT, 24, output sample width (signed two's complement).
- NUM_TAPS, 8, number of filter taps (taken from the package).
- COEF_W, 16, coefficient width, signed Q1.15 (taken from the package).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset.
- data_in  input  WD_IN  signed input sample, sampled on every rising edge of clk.
- data_out  output  WD_OUT  signed filtered sample, registered.

Interface (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Delay line x[0..7] clears to 0 immediately.
  - Output register clears to 0, so data_out=0x000000 immediately.
  - Reset has priority over any clock edge.
  - A reset asserted mid-stream discards all history. After release, the filter behaves as if all prior samples were 0.
- Every rising edge when rst_n=1:
  - x[0] <= data_in.
  - x[k] <= x[k-1] for k=1..7.
  - data_out <= sat24( floor( sum_k c[k]*x[k] / 2^15 ) ), computed from the delay line as it stood before this edge.
- Coefficients c[0..7], decimal Q1.15: 1024, 2048, 4096, 8192, 8192, 4096, 2048, 1024.
  - The set is symmetric, with sum 30720, so DC gain = 0.9375.
- Latency: a sample present at data_in before edge n contributes to data_out after edge n+1, i.e. 2 cycles.
- Arithmetic and width rules:
  - Products are signed 24x16 = 40 bits.
  - Accumulator is ACC_W=48 bits signed, with full precision and no intermediate truncation.
  - Scaling is an arithmetic right shift by 15, i.e. floor (rounds toward -inf). No rounding constant is added.
  - Saturation: results above +8388607 clamp to 0x7FFFFF; results below -8388608 clamp to 0x800000.
    - With the default coefficients saturation never triggers. It must still be implemented, because the coefficient set is a package constant.
- Behaviour is fully combinational-free at the output: data_out changes only on a clock edge or on reset.
- There are no X-propagation allowances: every register has a reset value.
- Implementation freedom: products may be summed by a balanced adder tree or a linear chain. Total latency must remain exactly 2 cycles; no additional pipeline stages are allowed.

Decomposition:
- Package fir_pkg holds:
  - NUM_TAPS=8, COEF_W=16, FRAC_BITS=15, ACC_W=48.
  - typedef coef_t (signed COEF_W).
  - typedef sample_t (signed 24).
  - localparam array COEFS[NUM_TAPS].
  - function sat24 (ACC_W -> 24 with clamping).
- One sub-module, fir_delay_line:
  - NUM_TAPS-deep shift register of sample_t with asynchronous active-low clear.
  - Exposes all taps as a packed array.
- Top fir_filter contains the MAC/adder tree, the shift/saturation, and the output register.

Test Plan:
1. Reset: hold rst_n=0 with data_in=0x123456 for 3 cycles -> data_out=0x000000 throughout. Release, then feed zeros -> data_out stays 0x000000.
2. Impulse: one sample 0x008000 followed by zeros -> starting 2 cycles later, data_out = 0x000400, 0x000800, 0x001000, 0x002000, 0x002000, 0x001000, 0x000800, 0x000400, then 0x000000.
3. DC step positive: constant 0x100000 -> output ramps and settles after 8 outputs at 0x0F0000. Constant 0xF00000 -> settles at 0xF10000.
4. Extremes / floor rounding:
   - Constant 0x7FFFFF -> settles at 0x77FFFF.
   - Constant 0x800000 -> settles at 0x880000.
   - Single sample 0xFFFFFF (-1) then zeros -> first output 0xFFFFFF (floor of -1024/32768).
5. Async reset mid-stream: while streaming a 0x100000 DC input, pulse rst_n low between clock edges -> data_out goes to 0 at once, not waiting for a clock edge. After release, the output ramps up again starting with 0x008000.
6. Sine stream: 64-sample full-scale sine, period 64 samples -> output is a sine delayed 2 cycles plus the filter group delay. Each output must equal a bit-exact reference model of the formula above.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types, constants and helpers for the 8-tap low-pass
//                FIR filter: sample/coefficient types, accumulator sizing,
//                the fixed Q1.15 coefficient set and the 24-bit saturator.
//  Ports       : (package - none)
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // ------------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------------
    localparam int NUM_TAPS  = 8;
    localparam int COEF_W    = 16;
    localparam int FRAC_BITS = 15;
    localparam int ACC_W     = 48;
    localparam int SAMPLE_W  = 24;

    // Full-precision product of one sample and one coefficient.
    localparam int PROD_W    = SAMPLE_W + COEF_W;

    // ------------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------------
    typedef logic signed [COEF_W-1:0]   coef_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // ------------------------------------------------------------------------
    // Coefficients, Q1.15. Symmetric (linear phase); they sum to 30720, which
    // gives a DC gain of 0.9375 and keeps the default set clear of saturation.
    // ------------------------------------------------------------------------
    localparam coef_t COEFS [NUM_TAPS] = '{
        16'sd1024, 16'sd2048, 16'sd4096, 16'sd8192,
        16'sd8192, 16'sd4096, 16'sd2048, 16'sd1024
    };

    // ------------------------------------------------------------------------
    // Saturation limits, expressed both at accumulator width (for comparing)
    // and at sample width (for the clamped result).
    // ------------------------------------------------------------------------
    localparam logic signed [ACC_W-1:0] ACC_SAT_HI =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_SAT_LO =
        {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // ------------------------------------------------------------------------
    // sat24: clamp an already-scaled accumulator value into the signed 24-bit
    // sample range. The default coefficients never reach the limits, but the
    // coefficient set is a package constant and may be retuned.
    // ------------------------------------------------------------------------
    function automatic sample_t sat24(input logic signed [ACC_W-1:0] value);
        sample_t result;
        if (value > ACC_SAT_HI) begin
            result = SAMPLE_MAX;
        end else if (value < ACC_SAT_LO) begin
            result = SAMPLE_MIN;
        end else begin
            result = value[SAMPLE_W-1:0];
        end
        return result;
    endfunction

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_filter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_filter_if
//  Description : Sample-stream bundle for the FIR filter. There is no
//                handshake: one sample enters and one leaves every clock.
//  Signals     : data_in  - signed input sample  (source -> filter)
//                data_out - signed filtered sample (filter -> consumer)
//  Modports    : master - sample source / consumer side
//                slave  - filter side
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_filter_if #(
    parameter int WD_IN  = 24,
    parameter int WD_OUT = 24
);

    logic signed [WD_IN-1:0]  data_in;
    logic signed [WD_OUT-1:0] data_out;

    modport master (
        output data_in,
        input  data_out
    );

    modport slave (
        input  data_in,
        output data_out
    );

endinterface : fir_filter_if
`default_nettype wire

// File: rtl/fir_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : fir_delay_line
//  Description : NUM_TAPS-deep shift register of signed samples. Every rising
//                edge the new sample enters tap 0 and each tap moves one place
//                further down the line. All taps are visible at once.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low clear of every tap
//                din   - incoming sample
//                taps  - packed array of all taps, taps[0] = newest
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_delay_line
    import fir_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  sample_t                      din,
    output sample_t [NUM_TAPS-1:0]       taps
);

    sample_t [NUM_TAPS-1:0] r_taps;

    // The oldest sample simply falls off the top of the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taps <= '0;
        end else begin
            r_taps <= {r_taps[NUM_TAPS-2:0], din};
        end
    end

    assign taps = r_taps;

endmodule : fir_delay_line
`default_nettype wire

// File: rtl/fir_filter.sv
`default_nettype none
// ============================================================================
//  Module      : fir_filter
//  Description : Fixed-coefficient 8-tap direct-form low-pass FIR for a signed
//                24-bit stream. One sample in and one sample out per clock.
//                Output = sat24(floor(sum c[k]*x[k] / 2^15)), registered.
//                Latency from data_in to data_out is two clocks: one in the
//                delay line, one in the output register.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset (clears history and
//                        output immediately)
//                bus   - fir_filter_if.slave (data_in / data_out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_filter
    import fir_pkg::*;
#(
    parameter int WD_IN  = 24,
    parameter int WD_OUT = 24
)(
    input  logic             clk,
    input  logic             rst_n,
    fir_filter_if.slave      bus
);

    // ------------------------------------------------------------------------
    // Input capture into the delay line
    // ------------------------------------------------------------------------
    logic signed [WD_IN-1:0]    w_din;
    sample_t                    w_sample;
    sample_t [NUM_TAPS-1:0]     w_taps;

    assign w_din    = bus.data_in;
    assign w_sample = sample_t'(w_din);

    fir_delay_line u_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (w_sample),
        .taps  (w_taps)
    );

    // ------------------------------------------------------------------------
    // Products: each is exact in PROD_W bits (24 x 16 signed). Both operands
    // are widened first so the multiply happens at full width.
    // ------------------------------------------------------------------------
    logic signed [PROD_W-1:0] w_prod [NUM_TAPS];

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_prod
        assign w_prod[k] = PROD_W'($signed(w_taps[k])) * PROD_W'(COEFS[k]);
    end

    // ------------------------------------------------------------------------
    // Accumulate at ACC_W with no intermediate truncation. Eight 40-bit terms
    // need at most 43 bits, so the 48-bit accumulator cannot wrap.
    // ------------------------------------------------------------------------
    logic signed [ACC_W-1:0] w_acc;

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_acc = w_acc + ACC_W'(w_prod[k]);
        end
    end

    // ------------------------------------------------------------------------
    // Scale back to the sample grid. Arithmetic shift = floor division, so
    // negative results round toward minus infinity (e.g. -1024/2^15 -> -1).
    // ------------------------------------------------------------------------
    logic signed [ACC_W-1:0] w_scaled;
    sample_t                 w_sat;

    assign w_scaled = w_acc >>> FRAC_BITS;
    assign w_sat    = sat24(w_scaled);

    // ------------------------------------------------------------------------
    // Output register: data_out only ever changes on a clock edge or reset.
    // ------------------------------------------------------------------------
    logic signed [WD_OUT-1:0] r_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else begin
            r_dout <= WD_OUT'(w_sat);
        end
    end

    assign bus.data_out = r_dout;

endmodule : fir_filter
`default_nettype wire

// File: tb/tb_fir_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_filter
//  Description : Self-checking bench for fir_filter. A reference model of the
//                filter equation produces the expected output for each driven
//                sample; expectations queue up and are compared as the DUT
//                produces its registered outputs two clocks later. Fixed
//                reference values are also compared at the notable points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_filter;

    localparam int c_clk_half = 5;

    logic clk;
    logic rst_n;

    fir_filter_if #(.WD_IN(24), .WD_OUT(24)) bus ();

    fir_filter #(.WD_IN(24), .WD_OUT(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #(c_clk_half) clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    int          c_ref_coef [8] = '{1024, 2048, 4096, 8192, 8192, 4096, 2048, 1024};
    int          r_hist [8];
    logic [23:0] r_sb [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [23:0] ref_out();
        longint acc;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            acc += longint'(r_hist[k]) * longint'(c_ref_coef[k]);
        end
        acc = acc >>> 15;
        if (acc > 64'sd8388607)  acc = 64'sd8388607;
        if (acc < -64'sd8388608) acc = -64'sd8388608;
        return acc[23:0];
    endfunction

    // History cleared, and the output after the first post-reset edge is 0.
    task automatic reset_model();
        for (int k = 0; k < 8; k++) r_hist[k] = 0;
        r_sb.delete();
        r_sb.push_back(24'h000000);
    endtask

    // Drive one sample, push its expected result, then pop and compare the
    // output that the DUT produces at this edge (queued one sample earlier).
    task automatic step(input logic signed [23:0] v);
        logic [23:0] exp_v;
        @(negedge clk);
        bus.data_in = v;
        for (int k = 7; k > 0; k--) r_hist[k] = r_hist[k-1];
        r_hist[0] = int'(v);
        r_sb.push_back(ref_out());
        @(posedge clk);
        #1;
        if (r_sb.size() > 0) begin
            exp_v = r_sb.pop_front();
            check_val("sb", bus.data_out, exp_v);
        end else begin
            check_val("sb_empty", bus.data_out, 24'hxxxxxx);
        end
    endtask

    task automatic run_const(input logic signed [23:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    logic [23:0] c_imp_tbl [9] = '{24'h000400, 24'h000800, 24'h001000, 24'h002000,
                                   24'h002000, 24'h001000, 24'h000800, 24'h000400,
                                   24'h000000};

    initial begin
        real         ph;
        logic signed [23:0] s;

        rst_n       = 1'b0;
        bus.data_in = 24'h123456;
        reset_model();

        // 1. Reset holds the output at zero regardless of input.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("reset", bus.data_out, 24'h000000);
        end
        rst_n = 1'b1;
        run_const(24'sh000000, 4);
        check_val("zeros", bus.data_out, 24'h000000);

        // 2. Impulse response equals the coefficient set scaled by 2^-15 * 2^15.
        step(24'sh008000);
        for (int i = 0; i < 9; i++) begin
            step(24'sh000000);
            check_val("impulse", bus.data_out, c_imp_tbl[i]);
        end

        // 3. DC steps.
        run_const(24'sh100000, 12);
        check_val("dc_pos", bus.data_out, 24'h0F0000);
        run_const(24'shF00000, 12);
        check_val("dc_neg", bus.data_out, 24'hF10000);

        // 4. Extremes and floor rounding.
        run_const(24'sh7FFFFF, 12);
        check_val("max", bus.data_out, 24'h77FFFF);
        run_const(24'sh800000, 12);
        check_val("min", bus.data_out, 24'h880000);
        run_const(24'sh000000, 12);
        step(24'shFFFFFF);
        step(24'sh000000);
        check_val("floor_neg1", bus.data_out, 24'hFFFFFF);
        run_const(24'sh000000, 10);

        // 5. Asynchronous reset mid-stream, asserted between edges.
        run_const(24'sh100000, 12);
        check_val("pre_rst", bus.data_out, 24'h0F0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst", bus.data_out, 24'h000000);
        @(posedge clk);
        #2;
        check_val("rst_hold", bus.data_out, 24'h000000);
        rst_n = 1'b1;
        reset_model();
        step(24'sh100000);
        check_val("ramp0", bus.data_out, 24'h000000);
        step(24'sh100000);
        check_val("ramp1", bus.data_out, 24'h008000);
        run_const(24'sh100000, 10);
        check_val("ramp_settle", bus.data_out, 24'h0F0000);

        // 6. Full-scale sine, period 64, two periods against the model.
        for (int i = 0; i < 128; i++) begin
            ph = 2.0 * 3.14159265358979 * real'(i % 64) / 64.0;
            s  = 24'($rtoi(8388607.0 * $sin(ph)));
            step(s);
        end
        run_const(24'sh000000, 10);
        check_val("tail", bus.data_out, 24'h000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fir_filter
`default_nettype wire
